// File: rtl/fft_channel_scheduler.sv
// fft_channel_scheduler: multi-channel job scheduler and interrupt aggregator
// in front of the single FFT engine. It validates per-channel start requests,
// queues one request per channel, dispatches them round-robin, and keeps
// sticky W1C done/error status with masked aggregate interrupts.
// Optional build macro FFT_SCHED_WATCHDOG_EN adds a RUN-state watchdog that
// aborts the engine after TIMEOUT_CYCLES clocks without completion.
//
// Handshake: every request/engine signal is a single-cycle pulse with no
// back-pressure. req_start_i[c] is sampled once per clock and either queued,
// rejected (error[c]) or, under flush_i, silently dropped. eng_start_o and
// eng_reset_o are one-cycle commands. eng_done_i and eng_error_i are one-cycle
// responses that only count while the FSM is in RUN.
module fft_channel_scheduler #(
  parameter int NUM_CH              = 4,
  parameter int FFT_MAX_LENGTH_LOG2 = 12,
  parameter int FFT_MIN_LENGTH_LOG2 = 8,
  parameter int LEN_W               = 4,
  parameter int TIMEOUT_CYCLES      = 65536,
  localparam int CH_W               = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic [NUM_CH-1:0]       req_start_i,
  input  logic [NUM_CH*LEN_W-1:0] req_len_log2_i,
  input  logic                    flush_i,
  input  logic [2*NUM_CH-1:0]     int_enable_i,
  input  logic [2*NUM_CH-1:0]     int_clear_i,
  output logic                    eng_start_o,
  output logic                    eng_reset_o,
  output logic [LEN_W-1:0]        eng_length_log2_o,
  input  logic                    eng_done_i,
  input  logic                    eng_error_i,
  output logic                    active_o,
  output logic [CH_W-1:0]         active_ch_o,
  output logic [NUM_CH-1:0]       pending_o,
  output logic [2*NUM_CH-1:0]     int_status_o,
  output logic                    irq_done_o,
  output logic                    irq_error_o,
  output logic [1:0]              fsm_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_ABORT} state_t;

  localparam logic [LEN_W-1:0] MIN_L    = LEN_W'(FFT_MIN_LENGTH_LOG2);
  localparam logic [LEN_W-1:0] MAX_L    = LEN_W'(FFT_MAX_LENGTH_LOG2);
  localparam logic [CH_W:0]    NUM_CH_X = (CH_W+1)'(NUM_CH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH-1);
  localparam logic [NUM_CH-1:0] ONE_CH  = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [NUM_CH-1:0]     pending_q;
  logic [LEN_W-1:0]      len_q [NUM_CH];
  logic [CH_W-1:0]       rr_ptr_q, act_ch_q, grant_ch;
  logic [LEN_W-1:0]      act_len_q, req_len;
  logic [2*NUM_CH-1:0]   status_q;
  logic [NUM_CH-1:0]     req_ok, req_err, act_oh, grant_oh, grant_clr;
  logic [NUM_CH-1:0]     done_set, err_set;
  logic [CH_W:0]         idx;
  logic                  grant_vld, grant_take, done_evt, err_evt, wd_expired;

`ifdef FFT_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES+1);
  logic [WD_W-1:0] wd_q;

  // Watchdog counts RUN cycles; restarts for every dispatched job.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)             wd_q <= '0;
    else if (state_q == S_START) wd_q <= '0;
    else if (state_q == S_RUN)   wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES-1));
`else
  // Parameter stays referenced so both builds share one parameter list.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
`endif

  // Classify each request: queue it, flag an error, or drop it under flush.
  always_comb begin
    req_ok  = '0;
    req_err = '0;
    req_len = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      req_len = req_len_log2_i[c*LEN_W +: LEN_W];
      if (req_start_i[c] && !flush_i) begin
        if (req_len < MIN_L || req_len > MAX_L) req_err[c] = 1'b1;
        else if (pending_q[c])                  req_err[c] = 1'b1;
        else                                    req_ok[c]  = 1'b1;
      end
    end
  end

  // Round-robin pick: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (idx >= NUM_CH_X) idx = idx - NUM_CH_X;
      if (!grant_vld && pending_q[idx[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = idx[CH_W-1:0];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state, engine commands and completion events.
  always_comb begin
    state_d     = state_q;
    grant_take  = 1'b0;
    done_evt    = 1'b0;
    err_evt     = 1'b0;
    eng_start_o = 1'b0;
    eng_reset_o = 1'b0;
    active_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (grant_vld && !flush_i) begin
          grant_take = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        eng_start_o = 1'b1;
        active_o    = 1'b1;
        state_d     = flush_i ? S_ABORT : S_RUN;
      end
      S_RUN: begin
        active_o = 1'b1;
        done_evt = eng_done_i;
        err_evt  = eng_error_i;
        if (flush_i)                        state_d = S_ABORT;
        else if (eng_done_i || eng_error_i) state_d = S_IDLE;
        else if (wd_expired)                state_d = S_ABORT;
      end
      S_ABORT: begin
        eng_reset_o = 1'b1;
        err_evt     = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign act_oh    = ONE_CH << act_ch_q;
  assign grant_oh  = ONE_CH << grant_ch;
  assign grant_clr = grant_take ? grant_oh : '0;
  assign done_set  = done_evt ? act_oh : '0;
  assign err_set   = req_err | (err_evt ? act_oh : '0);

  // Pending queue, length registers, active job latch and sticky status.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_q <= '0;
      rr_ptr_q  <= '0;
      act_ch_q  <= '0;
      act_len_q <= '0;
      status_q  <= '0;
      for (int c = 0; c < NUM_CH; c++) len_q[c] <= '0;
    end else begin
      pending_q <= flush_i ? '0 : ((pending_q & ~grant_clr) | req_ok);
      for (int c = 0; c < NUM_CH; c++) begin
        if (req_ok[c]) len_q[c] <= req_len_log2_i[c*LEN_W +: LEN_W];
      end
      if (grant_take) begin
        act_ch_q  <= grant_ch;
        act_len_q <= len_q[grant_ch];
        rr_ptr_q  <= (grant_ch == LAST_CH) ? '0 : grant_ch + CH_W'(1);
      end
      // A set in the same cycle as a W1C pulse wins.
      status_q <= (status_q & ~int_clear_i) | {err_set, done_set};
    end
  end

  assign eng_length_log2_o = (state_q == S_IDLE) ? '0 : act_len_q;
  assign active_ch_o       = (state_q == S_IDLE) ? '0 : act_ch_q;
  assign pending_o         = pending_q;
  assign int_status_o      = status_q;
  assign irq_done_o        = |(status_q[NUM_CH-1:0] & int_enable_i[NUM_CH-1:0]);
  assign irq_error_o       = |(status_q[2*NUM_CH-1:NUM_CH] & int_enable_i[2*NUM_CH-1:NUM_CH]);
  assign fsm_state_o       = state_q;

endmodule
